// File: rtl/keypad_pkg.sv
// Shared types, constants and the key map for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, HOLD, RELEASE} scan_state_t;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  // Row-major map: row 0 = "1 2 3 A" ... row 3 = "* 0 # D".
  function automatic logic [3:0] key_lookup(input logic [1:0] row_idx,
                                            input logic [1:0] col_idx);
    logic [3:0] code;
    case ({row_idx, col_idx})
      4'h0:    code = 4'h1;
      4'h1:    code = 4'h2;
      4'h2:    code = 4'h3;
      4'h3:    code = 4'hA;
      4'h4:    code = 4'h4;
      4'h5:    code = 4'h5;
      4'h6:    code = 4'h6;
      4'h7:    code = 4'hB;
      4'h8:    code = 4'h7;
      4'h9:    code = 4'h8;
      4'hA:    code = 4'h9;
      4'hB:    code = 4'hC;
      4'hC:    code = KEY_STAR;
      4'hD:    code = 4'h0;
      4'hE:    code = KEY_HASH;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/module_keypad_encoder.sv
// Combinational key encoder: row index + column vector -> {hit, code}.
module module_keypad_encoder
  import keypad_pkg::*;
(
  input  logic [1:0]      row_idx,
  input  logic [COLS-1:0] cols,
  output logic            hit,
  output logic [3:0]      code
);

  // Descending scan so the lowest active column is the last (winning) write.
  always_comb begin
    hit  = 1'b0;
    code = 4'h0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (cols[c]) begin
        hit  = 1'b1;
        code = key_lookup(row_idx, 2'(c));
      end
    end
  end

endmodule

// File: rtl/module_keypad_scan.sv
// 4x4 keypad row scanner feeding module_DeBounce; emits key_code/key_valid on confirmation.
// Optional KEYPAD_REPEAT_EN: keeps key_detect live in RELEASE so held keys auto-repeat.
module module_keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 27_000
) (
  input  logic            clk,
  input  logic            n_reset,
  input  logic [COLS-1:0] columnas_in,
  input  logic            db_out,
  output logic [ROWS-1:0] filas,
  output logic            key_detect,
  output logic [COLS-1:0] columnas_out,
  output logic [1:0]      fila_activa,
  output logic [3:0]      key_code,
  output logic            key_valid
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_VAL = CNT_W'(SCAN_DIV - 1);

  logic [COLS-1:0] r_col_m;
  logic [COLS-1:0] r_col_s;
  logic            r_db_q;
  logic [CNT_W-1:0] r_div_cnt;
  scan_state_t     r_state;
  logic [ROWS-1:0] r_filas;
  logic [1:0]      r_fila_activa;
  logic [3:0]      r_key_code;
  logic            r_key_valid;

  logic            w_tick;
  logic            w_col_any;
  logic            w_db_rise;
  logic            w_idle_exit;
  logic            w_hit;
  logic [3:0]      w_code;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_col_m <= '0;
      r_col_s <= '0;
      r_db_q  <= 1'b0;
    end else begin
      r_col_m <= columnas_in;
      r_col_s <= r_col_m;
      r_db_q  <= db_out;
    end
  end

  assign w_tick      = (r_div_cnt == TICK_VAL);
  assign w_col_any   = |r_col_s;
  assign w_db_rise   = db_out & ~r_db_q;
  assign w_idle_exit = w_tick & ~w_col_any & ~db_out;

  module_keypad_encoder u_encoder (
    .row_idx (r_fila_activa),
    .cols    (r_col_s),
    .hit     (w_hit),
    .code    (w_code)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state       <= SCAN;
      r_div_cnt     <= '0;
      r_filas       <= 4'b0001;
      r_fila_activa <= 2'd0;
      r_key_code    <= 4'h0;
      r_key_valid   <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      r_div_cnt   <= w_tick ? '0 : r_div_cnt + CNT_W'(1);
      case (r_state)
        SCAN: begin
          if (w_tick) begin
            if (w_col_any) begin
              r_state   <= HOLD;
              r_div_cnt <= '0;
            end else begin
              r_filas       <= {r_filas[ROWS-2:0], r_filas[ROWS-1]};
              r_fila_activa <= r_fila_activa + 2'd1;
            end
          end
        end
        HOLD: begin
          // A confirmation edge takes priority over a same-cycle release tick.
          if (w_db_rise) begin
            r_state     <= RELEASE;
            r_div_cnt   <= '0;
            r_key_valid <= w_hit;
            if (w_hit) r_key_code <= w_code;
          end else if (w_idle_exit) begin
            r_state       <= SCAN;
            r_div_cnt     <= '0;
            r_filas       <= {r_filas[ROWS-2:0], r_filas[ROWS-1]};
            r_fila_activa <= r_fila_activa + 2'd1;
          end
        end
        RELEASE: begin
`ifdef KEYPAD_REPEAT_EN
          if (w_db_rise && w_hit) r_key_valid <= 1'b1;
`endif
          if (w_idle_exit) begin
            r_state       <= SCAN;
            r_div_cnt     <= '0;
            r_filas       <= {r_filas[ROWS-2:0], r_filas[ROWS-1]};
            r_fila_activa <= r_fila_activa + 2'd1;
          end
        end
        default: begin
          r_state   <= SCAN;
          r_div_cnt <= '0;
        end
      endcase
    end
  end

`ifdef KEYPAD_REPEAT_EN
  assign key_detect = ((r_state == HOLD) || (r_state == RELEASE)) && w_col_any;
`else
  assign key_detect = (r_state == HOLD) && w_col_any;
`endif

  assign filas        = r_filas;
  assign columnas_out = r_col_s;
  assign fila_activa  = r_fila_activa;
  assign key_code     = r_key_code;
  assign key_valid    = r_key_valid;

endmodule

// File: tb/tb_module_keypad_scan.sv
// Scoreboard bench for module_keypad_scan with a keypad model and a simple debouncer model.
module tb_module_keypad_scan;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic [3:0] columnas_in;
  logic       db_out = 1'b0;
  logic [3:0] filas;
  logic       key_detect;
  logic [3:0] columnas_out;
  logic [1:0] fila_activa;
  logic [3:0] key_code;
  logic       key_valid;

  int errors = 0;
  int checks = 0;

  logic [3:0] sb_q[$];
  logic       press_en = 1'b0;
  logic [3:0] press_row = 4'b0;
  logic [3:0] press_cols = 4'b0;
  logic       prev_valid = 1'b0;
  logic       rep_allow = 1'b0;
  int         rep_cnt = 0;
  int         db_cnt = 0;
  int         db_hi = 0;

  module_keypad_scan #(.SCAN_DIV(4)) dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .columnas_in  (columnas_in),
    .db_out       (db_out),
    .filas        (filas),
    .key_detect   (key_detect),
    .columnas_out (columnas_out),
    .fila_activa  (fila_activa),
    .key_code     (key_code),
    .key_valid    (key_valid)
  );

  always #5 clk = ~clk;

  // Keypad: pressed columns read high only while their row is driven.
  always_comb columnas_in = (press_en && ((filas & press_row) != 4'b0)) ? press_cols : 4'b0;

  // Debouncer: db_out rises after 10 cycles of key_detect, stays high 50 cycles.
  always @(negedge clk) begin
    if (!n_reset) begin
      db_out = 1'b0;
      db_cnt = 0;
      db_hi  = 0;
    end else if (db_hi > 0) begin
      db_hi = db_hi - 1;
      if (db_hi == 0) db_out = 1'b0;
    end else if (key_detect) begin
      db_cnt = db_cnt + 1;
      if (db_cnt == 10) begin
        db_out = 1'b1;
        db_hi  = 50;
        db_cnt = 0;
      end
    end else begin
      db_cnt = 0;
    end
  end

  task automatic step();
    logic [3:0] exp_code;
    @(negedge clk);
    if (key_valid) begin
      checks++;
      if (prev_valid) begin
        errors++;
        $display("FAIL valid_pulse: key_valid high 2 cycles, required 1-cycle pulse");
      end else if (sb_q.size() > 0) begin
        exp_code = sb_q.pop_front();
        if (key_code !== exp_code) begin
          errors++;
          $display("FAIL key_code: got %h, required %h", key_code, exp_code);
        end
      end else if (rep_allow && key_code === 4'hF) begin
        rep_cnt++;
      end else begin
        errors++;
        $display("FAIL unexpected_valid: key_valid with code %h, required no pulse", key_code);
      end
    end
    prev_valid = key_valid;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_sb_empty(input int limit, input string name);
    int n = 0;
    while (sb_q.size() > 0 && n < limit) begin
      step();
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d codes pending after %0d cycles, required 0", name, sb_q.size(), limit);
      sb_q.delete();
    end
  endtask

  task automatic wait_detect(input int limit, input string name);
    int n = 0;
    while (key_detect !== 1'b1 && n < limit) begin
      step();
      n++;
    end
    checks++;
    if (key_detect !== 1'b1) begin
      errors++;
      $display("FAIL %s: key_detect=%b after %0d cycles, required 1", name, key_detect, limit);
    end
  endtask

  task automatic wait_filas(input logic [3:0] row, input int limit, input string name);
    int n = 0;
    while (filas !== row && n < limit) begin
      step();
      n++;
    end
    checks++;
    if (filas !== row) begin
      errors++;
      $display("FAIL %s: filas=%b, required %b within %0d cycles", name, filas, row, limit);
    end
  endtask

  task automatic test_reset();
    n_reset  = 1'b0;
    press_en = 1'b0;
    run(3);
    checks += 6;
    if (filas !== 4'b0001) begin errors++; $display("FAIL rst_filas: got %b, required 0001", filas); end
    if (key_detect !== 1'b0) begin errors++; $display("FAIL rst_key_detect: got %b, required 0", key_detect); end
    if (columnas_out !== 4'b0) begin errors++; $display("FAIL rst_columnas_out: got %b, required 0000", columnas_out); end
    if (fila_activa !== 2'd0) begin errors++; $display("FAIL rst_fila_activa: got %0d, required 0", fila_activa); end
    if (key_code !== 4'h0) begin errors++; $display("FAIL rst_key_code: got %h, required 0", key_code); end
    if (key_valid !== 1'b0) begin errors++; $display("FAIL rst_key_valid: got %b, required 0", key_valid); end
    n_reset = 1'b1;
  endtask

  task automatic test_idle_scan();
    logic [3:0] exp_row;
    run(2);
    for (int i = 0; i < 10; i++) begin
      exp_row = 4'(4'b0001 << (i % 4));
      checks++;
      if (filas !== exp_row || fila_activa !== 2'(i % 4) || key_detect !== 1'b0) begin
        errors++;
        $display("FAIL idle_scan[%0d]: filas=%b fila_activa=%0d key_detect=%b, required %b %0d 0",
                 i, filas, fila_activa, key_detect, exp_row, i % 4);
      end
      run(4);
    end
  endtask

  task automatic test_key5();
    press_row = 4'b0010; press_cols = 4'b0010; press_en = 1'b1;
    sb_q.push_back(4'h5);
    wait_detect(40, "key5_detect");
    checks++;
    if (filas !== 4'b0010 || fila_activa !== 2'd1 || columnas_out !== 4'b0010) begin
      errors++;
      $display("FAIL key5_freeze: filas=%b fila_activa=%0d columnas_out=%b, required 0010 1 0010",
               filas, fila_activa, columnas_out);
    end
    wait_sb_empty(60, "key5_valid");
    press_en = 1'b0;
    run(120);
    wait_filas(4'b0001, 20, "key5_resume_scan");
  endtask

  task automatic test_hold_hash();
`ifdef KEYPAD_REPEAT_EN
    rep_allow = 1'b1;
`endif
    rep_cnt = 0;
    press_row = 4'b1000; press_cols = 4'b0100; press_en = 1'b1;
    sb_q.push_back(4'hF);
    wait_sb_empty(80, "hash_valid");
    run(200);
`ifdef KEYPAD_REPEAT_EN
    checks++;
    if (rep_cnt < 2) begin
      errors++;
      $display("FAIL hash_repeat: %0d repeats, required at least 2", rep_cnt);
    end
`endif
    checks++;
    if (key_code !== 4'hF) begin
      errors++;
      $display("FAIL hash_code_held: got %h, required F", key_code);
    end
    press_en = 1'b0;
    run(120);
    rep_allow = 1'b0;
  endtask

  task automatic test_glitch();
    int n = 0;
    while (filas === 4'b1000 && n < 20) begin step(); n++; end
    wait_filas(4'b1000, 20, "glitch_reach_row3");
    press_row = 4'b1000; press_cols = 4'b0001; press_en = 1'b1;
    run(2);
    press_en = 1'b0;
    run(3);
    checks++;
    if (filas !== 4'b1000) begin
      errors++;
      $display("FAIL glitch_freeze: filas=%b, required 1000", filas);
    end
    wait_filas(4'b0001, 12, "glitch_return_scan");
    checks++;
    if (fila_activa !== 2'd0 || key_code !== 4'hF || key_detect !== 1'b0) begin
      errors++;
      $display("FAIL glitch_no_valid: fila_activa=%0d key_code=%h key_detect=%b, required 0 F 0",
               fila_activa, key_code, key_detect);
    end
  endtask

  task automatic test_multi_col();
    press_row = 4'b0001; press_cols = 4'b1001; press_en = 1'b1;
    sb_q.push_back(4'h1);
    wait_detect(40, "multi_detect");
    wait_sb_empty(60, "multi_valid");
    press_en = 1'b0;
    run(120);
  endtask

  task automatic test_reset_mid_press();
    press_row = 4'b0100; press_cols = 4'b0001; press_en = 1'b1;
    wait_detect(40, "midrst_detect");
    run(3);
    n_reset = 1'b0;
    #1;
    checks++;
    if (filas !== 4'b0001 || key_detect !== 1'b0 || columnas_out !== 4'b0 ||
        fila_activa !== 2'd0 || key_code !== 4'h0 || key_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs: filas=%b kd=%b cols=%b fa=%0d code=%h valid=%b, required 0001 0 0000 0 0 0",
               filas, key_detect, columnas_out, fila_activa, key_code, key_valid);
    end
    press_en = 1'b0;
    run(3);
    n_reset = 1'b1;
    run(2);
    checks++;
    if (filas !== 4'b0001) begin
      errors++;
      $display("FAIL midrst_scan_start: filas=%b, required 0001", filas);
    end
    run(4);
    checks++;
    if (filas !== 4'b0010 || fila_activa !== 2'd1) begin
      errors++;
      $display("FAIL midrst_scan_rotate: filas=%b fila_activa=%0d, required 0010 1", filas, fila_activa);
    end
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_key5();
    test_hold_hash();
    test_glitch();
    test_multi_col();
    test_reset_mid_press();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
